rom_read_arbiter: RTL and testbench

Two-port arbiter and read sequencer in front of the asynchronous 16x8 ROM model (4-bit addr, 8-bit data, active-low output enable, 1500 ps read delay).
- Grants one requester at a time and latches its address onto the ROM.
- Holds the output enable low for a fixed number of clocks to cover the ROM read delay.
- Captures the data and returns it to the requester with a one-cycle ack pulse.

---
 rtl/rom_read_arbiter_if.sv | 30 +++
 rtl/rom_read_arbiter.sv | 144 ++++++++++++++
 tb/tb_rom_read_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_if.sv
// Bundle between the ROM read arbiter, its two requesters and the ROM.
// The slave modport is the arbiter's view; the master modport is the requesters plus ROM.
`timescale 1ps/1ps
interface rom_arb_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_oeb;
    logic [DATA_W-1:0] rom_data;
    logic              busy;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output ack0, rdata0, ack1, rdata1, rom_addr, rom_oeb, busy
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  ack0, rdata0, ack1, rdata1, rom_addr, rom_oeb, busy
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-port arbiter and read sequencer for an asynchronous ROM: grant, hold oeb low, capture, ack.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
`timescale 1ps/1ps
module rom_read_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    rom_arb_if.slave  bus
);
    localparam int WAIT_EFF = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
    localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_EFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r,    state_nxt_s;
    logic [CNT_W-1:0]  cnt_r,      cnt_nxt_s;
    logic              gnt_r,      gnt_nxt_s;
    logic              last_gnt_r, last_gnt_nxt_s;
    logic [ADDR_W-1:0] rom_addr_r, rom_addr_nxt_s;
    logic              rom_oeb_r,  rom_oeb_nxt_s;
    logic              ack0_r,     ack0_nxt_s;
    logic              ack1_r,     ack1_nxt_s;
    logic [DATA_W-1:0] rdata0_r,   rdata0_nxt_s;
    logic [DATA_W-1:0] rdata1_r,   rdata1_nxt_s;
    logic              busy_r,     busy_nxt_s;
    logic              pick_s;

    // Returns the port to grant (0 or 1) given the requests and the previous grant.
    function automatic logic pick_port(input logic r0, input logic r1, input logic lg);
        logic p;
        if (r0 && r1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            p = 1'b0;
`else
            p = ~lg;
`endif
        end else if (r1) begin
            p = 1'b1;
        end else begin
            p = 1'b0;
        end
        return p;
    endfunction

    // Next-state and next-output logic for the grant/read/done sequence.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        gnt_nxt_s      = gnt_r;
        last_gnt_nxt_s = last_gnt_r;
        rom_addr_nxt_s = rom_addr_r;
        rom_oeb_nxt_s  = rom_oeb_r;
        ack0_nxt_s     = 1'b0;
        ack1_nxt_s     = 1'b0;
        rdata0_nxt_s   = rdata0_r;
        rdata1_nxt_s   = rdata1_r;
        pick_s         = pick_port(bus.req0, bus.req1, last_gnt_r);
        case (state_r)
            IDLE: begin
                rom_oeb_nxt_s = 1'b1;
                if (bus.req0 || bus.req1) begin
                    gnt_nxt_s      = pick_s;
                    last_gnt_nxt_s = pick_s;
                    rom_addr_nxt_s = pick_s ? bus.addr1 : bus.addr0;
                    rom_oeb_nxt_s  = 1'b0;
                    cnt_nxt_s      = {CNT_W{1'b0}};
                    state_nxt_s    = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    rom_oeb_nxt_s = 1'b1;
                    state_nxt_s   = DONE;
                    // rdata of the port not being served is left untouched
                    if (gnt_r) begin
                        rdata1_nxt_s = bus.rom_data;
                        ack1_nxt_s   = 1'b1;
                    end else begin
                        rdata0_nxt_s = bus.rom_data;
                        ack0_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = READ;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s   = IDLE;
                rom_oeb_nxt_s = 1'b1;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and output registers; reset abandons any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            gnt_r      <= 1'b0;
            last_gnt_r <= 1'b1;
            rom_addr_r <= {ADDR_W{1'b0}};
            rom_oeb_r  <= 1'b1;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            rdata0_r   <= {DATA_W{1'b0}};
            rdata1_r   <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            gnt_r      <= gnt_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
            rom_addr_r <= rom_addr_nxt_s;
            rom_oeb_r  <= rom_oeb_nxt_s;
            ack0_r     <= ack0_nxt_s;
            ack1_r     <= ack1_nxt_s;
            rdata0_r   <= rdata0_nxt_s;
            rdata1_r   <= rdata1_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign bus.ack0     = ack0_r;
    assign bus.ack1     = ack1_r;
    assign bus.rdata0   = rdata0_r;
    assign bus.rdata1   = rdata1_r;
    assign bus.rom_addr = rom_addr_r;
    assign bus.rom_oeb  = rom_oeb_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: delayed-ROM model, directed scenarios then random request mixes
// checked against a transaction-level arbitration model.
`timescale 1ps/1ps
module tb_rom_read_arbiter;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int WAIT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #500 clk = ~clk;

    rom_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Asynchronous ROM: data appears 1500 ps after address/oeb change
    logic [7:0] mem [16];
    logic [7:0] rom_q = 8'h00;
    always @(bus.rom_addr or bus.rom_oeb)
        rom_q <= #1500 (bus.rom_oeb ? 8'h00 : mem[bus.rom_addr]);
    assign bus.rom_data = rom_q;

    int checks = 0;
    int passed = 0;

    bit         pend0, pend1, last_gnt, idle;
    logic [3:0] paddr0, paddr1;
    logic [7:0] exp_rd0, exp_rd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit model_winner(input bit p0, input bit p1, input bit lg);
        if (p0 && p1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return ~lg;
`endif
        end
        return p1 && !p0;
    endfunction

    task automatic model_reset();
        last_gnt = 1'b1;
        exp_rd0  = 8'h00;
        exp_rd1  = 8'h00;
        pend0    = 1'b0;
        pend1    = 1'b0;
        idle     = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #10;
        check("rst_oeb",    32'(bus.rom_oeb),  32'd1);
        check("rst_busy",   32'(bus.busy),     32'd0);
        check("rst_ack",    32'({bus.ack0, bus.ack1}), 32'd0);
        check("rst_rdata0", 32'(bus.rdata0),   32'd0);
        check("rst_rdata1", 32'(bus.rdata1),   32'd0);
        check("rst_addr",   32'(bus.rom_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_step();
        @(posedge clk);
        @(negedge clk);
        idle = 1'b1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ack",  32'(bus.ack0 | bus.ack1), 32'd0);
        check("idle_oeb",  32'(bus.rom_oeb), 32'd1);
    endtask

    // Raise new requests, predict the winner, follow the read until its ack.
    task automatic round(input bit n0, input bit n1, input logic [3:0] a0, input logic [3:0] a1,
                         input bit chg, input logic [3:0] chg_a);
        bit         win;
        bit         seen;
        logic [3:0] waddr;
        int         cycles, low, busy_n;
        if (n0 && !pend0) begin pend0 = 1'b1; paddr0 = a0; bus.addr0 = a0; bus.req0 = 1'b1; end
        if (n1 && !pend1) begin pend1 = 1'b1; paddr1 = a1; bus.addr1 = a1; bus.req1 = 1'b1; end
        if (!pend0 && !pend1) return;
        win      = model_winner(pend0, pend1, last_gnt);
        last_gnt = win;
        waddr    = win ? paddr1 : paddr0;
        cycles = 0; low = 0; busy_n = 0; seen = 1'b0;
        while (!seen && cycles < 12) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            check("ack_excl", 32'(bus.ack0 & bus.ack1), 32'd0);
            if (bus.busy) busy_n++;
            if (!bus.rom_oeb) begin
                low++;
                check("rom_addr_hold", 32'(bus.rom_addr), 32'(waddr));
                if (low == 1 && chg) begin
                    if (win) bus.addr1 = chg_a;
                    else     bus.addr0 = chg_a;
                end
            end
            if (bus.ack0 || bus.ack1) seen = 1'b1;
        end
        check("ack_seen",  32'(seen), 32'd1);
        check("ack_port0", 32'(bus.ack0), 32'(!win));
        check("ack_port1", 32'(bus.ack1), 32'(win));
        if (win) exp_rd1 = mem[waddr];
        else     exp_rd0 = mem[waddr];
        check("rdata0",   32'(bus.rdata0), 32'(exp_rd0));
        check("rdata1",   32'(bus.rdata1), 32'(exp_rd1));
        check("oeb_low",  32'(low),    32'(WAIT));
        check("busy_cnt", 32'(busy_n), 32'(WAIT + 1));
        check("latency",  32'(cycles), idle ? 32'(WAIT + 1) : 32'(WAIT + 2));
        if (win) begin bus.req1 = 1'b0; pend1 = 1'b0; end
        else     begin bus.req0 = 1'b0; pend0 = 1'b0; end
        idle = 1'b0;
    endtask

    initial begin
        bit n0, n1;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[3]  = 8'hA5;
        mem[7]  = 8'h3C;
        mem[15] = 8'h81;
        mem[0]  = 8'h11;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.addr0 = 4'h0;
        bus.addr1 = 4'h0;
        model_reset();

        @(negedge clk);
        do_reset();

        // single read on port 0
        round(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 4'h0);
        idle_step();

        // contention straight out of reset, port 0 first
        do_reset();
        round(1'b1, 1'b1, 4'h7, 4'hF, 1'b0, 4'h0);
        round(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        idle_step();

        // both ports hold requests across four transactions
        for (int i = 0; i < 4; i++)
            round(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 4'h0);
        while (pend0 || pend1) round(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        idle_step();

        // address changed right after grant
        round(1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 4'h3);
        check("addr_chg_rdata1", 32'(bus.rdata1), 32'h11);
        idle_step();

        // reset one clock after grant
        bus.addr0 = 4'h7;
        bus.req0  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_oeb_low", 32'(bus.rom_oeb), 32'd0);
        @(posedge clk);
        #100;
        rst_n = 1'b0;
        #10;
        check("mid_oeb",    32'(bus.rom_oeb), 32'd1);
        check("mid_busy",   32'(bus.busy),    32'd0);
        check("mid_ack",    32'({bus.ack0, bus.ack1}), 32'd0);
        check("mid_rdata0", 32'(bus.rdata0),  32'd0);
        check("mid_rdata1", 32'(bus.rdata1),  32'd0);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("mid_no_ack", 32'(bus.ack0), 32'd0);
        rst_n = 1'b1;
        model_reset();
        round(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0);
        idle_step();

        // boundary addresses back to back
        round(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0);
        round(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        check("boundary_rdata0", 32'(bus.rdata0), 32'h11);
        idle_step();

        // random request mixes
        for (int i = 0; i < 40; i++) begin
            n0 = 1'($urandom_range(0, 1));
            n1 = 1'($urandom_range(0, 1));
            if (!n0 && !n1 && !pend0 && !pend1) n0 = 1'b1;
            round(n0, n1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if (!pend0 && !pend1 && $urandom_range(0, 2) == 0) idle_step();
        end
        while (pend0 || pend1) round(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        idle_step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
